// File: rtl/rsa_stream_loader_if.sv
// Byte-stream ports of rsa_stream_loader: block input (s_*) and result output (m_*).
interface rsa_stream_loader_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    // master: environment that feeds input bytes and sinks result bytes
    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_last);
    // slave: the loader itself
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/rsa_stream_loader.sv
// Byte-stream front end for the RSA core: assembles a 16-byte block, runs the core, streams the result.
// Optional RUN watchdog enabled by defining RSA_LOADER_TIMEOUT_EN.
module rsa_stream_loader #(
    parameter int unsigned START_CYCLES   = 1,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rsa_stream_loader_if.slave   io,
    input  logic [1:0]           mode,
    output logic                 busy,
    output logic                 err,
    output logic                 core_new,
    output logic [255:0]         core_in,
    output logic [1:0]           core_ed,
    input  logic [1:0]           core_done,
    input  logic [255:0]         core_out
);

    localparam int unsigned BLK_BYTES = 16;
    localparam int unsigned ENC_BYTES = 32;
    localparam int unsigned DEC_BYTES = 16;
    localparam int unsigned CNT_W     = 6;
    localparam logic [1:0]  MODE_ENC  = 2'b10;
    localparam logic [1:0]  MODE_DEC  = 2'b01;

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [127:0]       blk_q, blk_d;
    logic [3:0]         byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [31:0]        start_cnt_q, start_cnt_d;
    logic [255:0]       shift_q, shift_d;
    logic [255:0]       core_in_q, core_in_d;
    logic [1:0]         core_ed_q, core_ed_d;
    logic               core_new_q, core_new_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;
    logic               m_last_q, m_last_d;
`ifdef RSA_LOADER_TIMEOUT_EN
    logic [31:0]        tmo_q, tmo_d;
`endif

    logic s_hs;
    logic m_hs;
    logic is_enc;

    assign s_hs   = io.s_valid & s_ready_q;
    assign m_hs   = m_valid_q & io.m_ready;
    assign is_enc = (core_ed_q == MODE_ENC);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            byte_cnt_q  <= '0;
            drain_cnt_q <= '0;
            start_cnt_q <= '0;
            shift_q     <= '0;
            core_in_q   <= '0;
            core_ed_q   <= '0;
            core_new_q  <= 1'b1;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
`ifdef RSA_LOADER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            byte_cnt_q  <= byte_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            start_cnt_q <= start_cnt_d;
            shift_q     <= shift_d;
            core_in_q   <= core_in_d;
            core_ed_q   <= core_ed_d;
            core_new_q  <= core_new_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
`ifdef RSA_LOADER_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        byte_cnt_d  = byte_cnt_q;
        drain_cnt_d = drain_cnt_q;
        start_cnt_d = start_cnt_q;
        shift_d     = shift_q;
        core_in_d   = core_in_q;
        core_ed_d   = core_ed_q;
        core_new_d  = core_new_q;
        err_d       = 1'b0;
        s_ready_d   = s_ready_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
`ifdef RSA_LOADER_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (s_hs) begin
                    core_ed_d = mode;
                    if (mode == MODE_ENC || mode == MODE_DEC) begin
                        blk_d[7:0] = io.s_data;
                        byte_cnt_d = 4'd1;
                        state_d    = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (s_hs) begin
                    blk_d[{byte_cnt_q, 3'b000} +: 8] = io.s_data;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'(BLK_BYTES - 1)) begin
                        // Encrypt spreads the block over two 128-bit halves, decrypt packs it low
                        core_in_d   = is_enc ? {64'b0, blk_d[127:64], 64'b0, blk_d[63:0]}
                                             : {128'b0, blk_d};
                        s_ready_d   = 1'b0;
                        start_cnt_d = '0;
                        state_d     = START;
                    end
                end
            end
            START: begin
                core_new_d = 1'b1;
                if (start_cnt_q == 32'(START_CYCLES - 1)) begin
                    core_new_d = 1'b0;
                    state_d    = RUN;
`ifdef RSA_LOADER_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                end else begin
                    start_cnt_d = start_cnt_q + 32'd1;
                end
            end
            RUN: begin
                if (core_done == core_ed_q) begin
                    shift_d     = is_enc ? core_out : {128'b0, core_out[127:0]};
                    drain_cnt_d = is_enc ? CNT_W'(ENC_BYTES) : CNT_W'(DEC_BYTES);
                    m_valid_d   = 1'b1;
                    m_last_d    = 1'b0;
                    core_new_d  = 1'b1;
                    state_d     = DRAIN;
                end else if (core_done != 2'b00) begin
                    err_d      = 1'b1;
                    core_new_d = 1'b1;
                    s_ready_d  = 1'b1;
                    state_d    = IDLE;
                end
`ifdef RSA_LOADER_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    err_d      = 1'b1;
                    core_new_d = 1'b1;
                    s_ready_d  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            DRAIN: begin
                if (m_hs) begin
                    if (drain_cnt_q == CNT_W'(1)) begin
                        m_valid_d   = 1'b0;
                        m_last_d    = 1'b0;
                        drain_cnt_d = '0;
                        s_ready_d   = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        shift_d     = shift_q >> 8;
                        drain_cnt_d = drain_cnt_q - CNT_W'(1);
                        m_last_d    = (drain_cnt_q == CNT_W'(2));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign io.s_ready = s_ready_q;
    assign io.m_valid = m_valid_q;
    assign io.m_data  = shift_q[7:0];
    assign io.m_last  = m_last_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign core_new   = core_new_q;
    assign core_in    = core_in_q;
    assign core_ed    = core_ed_q;

endmodule

// File: tb/tb_rsa_stream_loader.sv
// Self-checking bench for rsa_stream_loader: expected result-byte queue plus a small core model.
module tb_rsa_stream_loader;

    localparam int unsigned SC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   mode;
    logic         busy, err, core_new;
    logic [255:0] core_in;
    logic [1:0]   core_ed;
    logic [1:0]   core_done;
    logic [255:0] core_out;

    rsa_stream_loader_if io ();

    rsa_stream_loader #(.START_CYCLES(SC), .TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .rst_n(rst_n), .io(io), .mode(mode), .busy(busy), .err(err),
        .core_new(core_new), .core_in(core_in), .core_ed(core_ed),
        .core_done(core_done), .core_out(core_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]   exp_q[$];
    int           obs_cnt, last_cnt;
    logic [7:0]   first_b, last_b;
    bit           tog = 1'b0;
    int           core_lat = -1;
    logic [1:0]   resp_done = 2'b00;
    logic [255:0] resp_out = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sink handshake driver
    initial begin
        io.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            io.m_ready = tog ? ~io.m_ready : 1'b1;
        end
    end

    // Core model: holds done/OUT after a latency in RUN, clears while new is high
    initial begin
        int run_cyc;
        run_cyc   = 0;
        core_done = 2'b00;
        core_out  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (core_new !== 1'b0) begin
                core_done = 2'b00;
                run_cyc   = 0;
            end else begin
                run_cyc++;
                if (core_lat >= 0 && run_cyc >= core_lat) begin
                    core_done = resp_done;
                    core_out  = resp_out;
                end
            end
        end
    end

    // Output compare against the expected byte queue, every cycle
    bit         stall_prev = 1'b0;
    bit         drained = 1'b0;
    logic [7:0] data_prev;
    always @(negedge clk) begin
        if (rst_n) begin
            if (drained) begin
                chk("s_ready_after_drain", 256'(io.s_ready), 256'(1));
                drained = 1'b0;
            end
            if (stall_prev) begin
                chk("hold_valid", 256'(io.m_valid), 256'(1));
                chk("hold_data", 256'(io.m_data), 256'(data_prev));
            end
            if (io.m_valid) begin
                chk("s_ready_low_in_drain", 256'(io.s_ready), 256'(0));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected no byte", io.m_data);
                end else begin
                    chk("m_data", 256'(io.m_data), 256'(exp_q[0]));
                    chk("m_last", 256'(io.m_last), 256'(exp_q.size() == 1));
                    if (io.m_ready) begin
                        if (obs_cnt == 0) first_b = io.m_data;
                        obs_cnt++;
                        if (io.m_last) begin
                            last_b = io.m_data;
                            last_cnt++;
                        end
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) drained = 1'b1;
                    end
                end
            end else begin
                chk("m_last_idle", 256'(io.m_last), 256'(0));
            end
            stall_prev = io.m_valid && !io.m_ready;
            data_prev  = io.m_data;
        end else begin
            stall_prev = 1'b0;
            drained    = 1'b0;
        end
    end

    // Result model: encrypt yields all 32 OUT bytes, decrypt the low 16, LSB first
    task automatic expect_result(input logic [1:0] md, input logic [255:0] out);
        int n;
        n = (md == 2'b10) ? 32 : 16;
        exp_q.delete();
        obs_cnt  = 0;
        last_cnt = 0;
        first_b  = '0;
        last_b   = '0;
        for (int k = 0; k < n; k++) exp_q.push_back(out[8*k +: 8]);
    endtask

    task automatic set_core(input int lat, input logic [1:0] d, input logic [7:0] base);
        core_lat  = lat;
        resp_done = d;
        for (int k = 0; k < 32; k++) resp_out[8*k +: 8] = 8'(int'(base) + k);
    endtask

    // Sends 16 bytes; mode is driven only with the first, junk afterwards
    task automatic send_block(input logic [1:0] md, input logic [7:0] first);
        for (int k = 0; k < 16; k++) begin
            int g;
            io.s_valid = 1'b1;
            io.s_data  = 8'(int'(first) + k);
            mode       = (k == 0) ? md : 2'b11;
            g = 0;
            while (!io.s_ready && g < 100) begin
                tick();
                g++;
            end
            if (g == 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL s_ready_wait: got 0 expected 1");
            end
            tick();
        end
        io.s_valid = 1'b0;
        mode       = 2'b00;
    endtask

    task automatic wait_run();
        int c;
        c = 0;
        while (core_new && c < 50) begin
            c++;
            tick();
        end
        chk("start_cycles", 256'(c), 256'(SC));
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            tick();
            g++;
        end
        if (g == 400) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_wait: got %0d bytes left expected 0", exp_q.size());
        end
        tick();
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"}, 256'(io.s_ready), 256'(1));
        chk({tag, "_m_valid"}, 256'(io.m_valid), 256'(0));
        chk({tag, "_m_data"}, 256'(io.m_data), 256'(0));
        chk({tag, "_m_last"}, 256'(io.m_last), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_err"}, 256'(err), 256'(0));
        chk({tag, "_core_new"}, 256'(core_new), 256'(1));
        chk({tag, "_core_in"}, core_in, 256'(0));
        chk({tag, "_core_ed"}, 256'(core_ed), 256'(0));
    endtask

    task automatic encrypt_block(input string tag);
        set_core(50, 2'b10, 8'h20);
        expect_result(2'b10, resp_out);
        send_block(2'b10, 8'h00);
        chk({tag, "_core_in"}, core_in,
            {64'b0, 64'h0F0E0D0C0B0A0908, 64'b0, 64'h0706050403020100});
        chk({tag, "_core_ed"}, 256'(core_ed), 256'(2'b10));
        wait_run();
        wait_drain();
        chk({tag, "_count"}, 256'(obs_cnt), 256'(32));
        chk({tag, "_first"}, 256'(first_b), 256'(8'h20));
        chk({tag, "_last"}, 256'(last_b), 256'(8'h3F));
        chk({tag, "_last_count"}, 256'(last_cnt), 256'(1));
        chk({tag, "_idle"}, 256'(busy), 256'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit saw_err;
        int n;
        rst_n      = 1'b0;
        mode       = 2'b00;
        io.s_valid = 1'b0;
        io.s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Encrypt
        encrypt_block("enc");

        // Decrypt: only OUT[127:0] comes back
        set_core(30, 2'b01, 8'h80);
        expect_result(2'b01, resp_out);
        send_block(2'b01, 8'hF0);
        chk("dec_core_in_hi", 256'(core_in[255:128]), 256'(0));
        chk("dec_core_in_lo", 256'(core_in[127:0]), 256'(128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0));
        wait_run();
        wait_drain();
        chk("dec_count", 256'(obs_cnt), 256'(16));
        chk("dec_first", 256'(first_b), 256'(8'h80));
        chk("dec_last", 256'(last_b), 256'(8'h8F));

        // Backpressure on the output stream
        tog = 1'b1;
        encrypt_block("bp");
        tog = 1'b0;

        // Invalid modes drop the byte and pulse err
        for (int i = 0; i < 2; i++) begin
            io.s_valid = 1'b1;
            io.s_data  = 8'h55;
            mode       = (i == 0) ? 2'b00 : 2'b11;
            tick();
            io.s_valid = 1'b0;
            chk("badmode_err", 256'(err), 256'(1));
            chk("badmode_busy", 256'(busy), 256'(0));
            chk("badmode_s_ready", 256'(io.s_ready), 256'(1));
            tick();
            chk("badmode_err_clear", 256'(err), 256'(0));
        end

        // Core reports done=11
        set_core(5, 2'b11, 8'h00);
        exp_q.delete();
        send_block(2'b10, 8'h00);
        wait_run();
        n = 0;
        while (!err && n < 200) begin
            tick();
            n++;
        end
        chk("core_err_seen", 256'(err), 256'(1));
        chk("core_err_busy", 256'(busy), 256'(0));
        chk("core_err_s_ready", 256'(io.s_ready), 256'(1));
        chk("core_err_core_new", 256'(core_new), 256'(1));
        tick();
        chk("core_err_pulse", 256'(err), 256'(0));

        // Core never answers
        set_core(-1, 2'b10, 8'h00);
        send_block(2'b10, 8'h00);
        wait_run();
`ifdef RSA_LOADER_TIMEOUT_EN
        n = 0;
        while (!err && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 256'(n), 256'(100));
        chk("timeout_busy", 256'(busy), 256'(0));
        chk("timeout_core_new", 256'(core_new), 256'(1));
        tick();
        chk("timeout_pulse", 256'(err), 256'(0));
`else
        saw_err = 1'b0;
        repeat (1000) begin
            tick();
            if (err) saw_err = 1'b1;
        end
        chk("no_timeout_err", 256'(saw_err), 256'(0));
        chk("no_timeout_busy", 256'(busy), 256'(1));
        chk("no_timeout_core_new", 256'(core_new), 256'(0));
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset 10 cycles into RUN
        send_block(2'b10, 8'h00);
        wait_run();
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrun");
        tick();
        rst_n = 1'b1;
        tick();
        encrypt_block("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_stream_loader.md
# rsa_stream_loader

Byte-stream front end for the RSA encrypt/decrypt core. Accepts plaintext or ciphertext bytes over a valid/ready stream and assembles one block. It then sequences the core's `new`/`done` handshake, captures the result, and streams the result bytes out over a second valid/ready port. It sits directly upstream of the core (drives `new`, `IN`, `E_D`) and directly downstream of it (consumes `done`, `OUT`).

## Interface
- `START_CYCLES`, 1: cycles `core_new` is held high in START before release; legal range ≥1.
- `TIMEOUT_CYCLES`, 32'd1048576: RUN-state watchdog limit; used only with `RSA_LOADER_TIMEOUT_EN`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  2  2'b10 encrypt, 2'b01 decrypt; sampled on the first byte of a block.
- `s_valid`  in  1  input byte valid.
- `s_ready`  out  1  loader can accept a byte.
- `s_data`  in  8  input byte.
- `m_valid`  out  1  output byte valid.
- `m_ready`  in  1  sink accepts output byte.
- `m_data`  out  8  output byte.
- `m_last`  out  1  marks the final byte of a result block.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse on an invalid mode, a bad `core_done`, or a timeout.
- `core_new`  out  1  to core `new`; high holds the core in init.
- `core_in`  out  256  to core `IN`.
- `core_ed`  out  2  to core `E_D`.
- `core_done`  in  2  from core `done`.
- `core_out`  in  256  from core `OUT`.

## Operation
- States: IDLE, LOAD, START, RUN, DRAIN.
- IDLE:
  - `s_ready`=1.
  - On the first byte handshake, latch `mode` into `core_ed`.
  - If `mode` is 2'b00 or 2'b11, drop the byte, pulse `err`, and stay in IDLE.
  - Otherwise store the byte and go to LOAD.
- LOAD:
  - `s_ready`=1. Accept bytes until 16 are held; byte k lands in `blk[8k+7:8k]`.
  - The `mode` input is ignored.
  - After the 16th byte, form `core_in` and go to START.
- `core_in` format:
  - Encrypt: {64'b0, blk[127:64], 64'b0, blk[63:0]}.
  - Decrypt: {128'b0, blk}.
  - `core_in` holds stable until the next block's START.
- START: `core_new`=1 for `START_CYCLES` cycles, then go to RUN.
- RUN:
  - `core_new`=0.
  - If `core_done` == `core_ed`, capture `core_out` into a 256-bit shift register, set `core_new`=1, and go to DRAIN.
  - If `core_done` is nonzero and ≠ `core_ed` (including 2'b11), pulse `err`, set `core_new`=1, discard the result, and go to IDLE.
- DRAIN:
  - Output byte count: 32 for encrypt, 16 for decrypt (`core_out[127:0]`).
  - `m_data` = shift[7:0], presented LSB byte first.
  - On each `m_valid & m_ready`, shift right by 8 and decrement the count.
  - `m_last` is high while the final byte is presented.
  - After the last handshake go to IDLE.
- `s_ready`=0 in START, RUN and DRAIN. A held `s_valid` simply stalls.
- `m_valid` and `m_data` stay stable until accepted.
- `core_new` is 0 only in RUN.

## Timing
- Reset values:
  - `s_ready`=1, `m_valid`=0, `m_data`=0, `m_last`=0.
  - `busy`=0, `err`=0.
  - `core_new`=1, `core_in`=0, `core_ed`=0.
  - State IDLE; byte and drain counters 0.
- All outputs are registered.
- 16th byte accepted at edge t: START for cycles t+1 .. t+START_CYCLES; `core_new` falls at t+START_CYCLES+1.
- `core_done` match sampled at edge d: `m_valid`=1 with byte 0 from edge d+1.
- Full throughput in DRAIN: 1 byte/cycle when `m_ready` is held high.
- Last output handshake at edge e: `s_ready`=1 from e+1. No overlap between loading and draining.
- Reset asserted mid-operation (any state) returns to reset values immediately. A partial block or partial output is discarded, and `core_new`=1 puts the core back into init.
- `err` is never asserted for more than one cycle per event.

## Configuration
- `RSA_LOADER_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to RUN and increments each RUN cycle.
  - On reaching `TIMEOUT_CYCLES` without a valid `core_done`: pulse `err`, set `core_new`=1, and go to IDLE.
- Not defined: no counter; RUN waits indefinitely for `core_done`.

## Test plan
- Encrypt:
  - Stimulus: `mode`=10, bytes 0x00..0x0F.
  - Check `core_in` = {64'b0, 64'h0F0E0D0C0B0A0908, 64'b0, 64'h0706050403020100}.
  - Core model returns `done`=10 after 50 cycles with `OUT` bytes 0x20..0x3F.
  - Expect 32 output bytes 0x20..0x3F, with `m_last` only on 0x3F.
- Decrypt:
  - Stimulus: `mode`=01, bytes 0xF0..0xFF.
  - Check `core_in[255:128]`=0 and `core_in[127:0]` = 128'hFFFE..F1F0.
  - Model returns `done`=01; expect exactly 16 bytes = `OUT[127:0]`, LSB first, `m_last` on the 16th.
- Backpressure:
  - `m_ready` toggles 1,0,1,0 during an encrypt drain.
  - `m_data` holds while stalled, all 32 bytes arrive in order, `s_ready` stays 0 until after the final handshake.
- Core error: model returns `done`=11 in RUN → one-cycle `err`, no `m_valid`, `core_new`=1, IDLE next cycle.
- Reset mid-RUN:
  - Deassert `rst_n` 10 cycles into RUN → all outputs at reset values immediately, `core_new`=1.
  - A following clean encrypt block completes correctly.
- Timeout (macro defined, `TIMEOUT_CYCLES`=100): model never asserts `done` → `err` pulse exactly 100 cycles after RUN entry, then IDLE.
- Timeout (macro undefined): with the same stimulus the loader is still in RUN after 1000 cycles.
